// File: rtl/adc_acq_sequencer_if.sv
// Host/datapath bundle for the ADC acquisition sequencer.
// The master side issues configuration and commands. The slave side is the sequencer, which returns control and status.
interface adc_acq_sequencer_if;
    // Handshake: cfg_start is a one-cycle request. It is taken only while busy is 0;
    // otherwise it is dropped. busy therefore acts as the inverse of ready.
    // cfg_abort is always honoured and beats a cfg_start in the same cycle.
    logic        cfg_start;
    logic        cfg_abort;
    logic [15:0] cfg_passes;
    logic [2:0]  cfg_ch_even;
    logic [2:0]  cfg_ch_odd;
    logic        cfg_uni;

    logic        adc_start;
    logic [31:0] adc_config_even;
    logic [31:0] adc_config_odd;
    logic        adc_wr_en;
    logic        clr_we;
    logic [11:0] clr_addr;
    logic        busy;
    logic        done;
    logic [15:0] pass_count;

    modport master (
        output cfg_start, cfg_abort, cfg_passes, cfg_ch_even, cfg_ch_odd, cfg_uni,
        input  adc_start, adc_config_even, adc_config_odd, adc_wr_en,
               clr_we, clr_addr, busy, done, pass_count
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_passes, cfg_ch_even, cfg_ch_odd, cfg_uni,
        output adc_start, adc_config_even, adc_config_odd, adc_wr_en,
               clr_we, clr_addr, busy, done, pass_count
    );
endinterface

// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer: zero-fills the capture RAM and then runs N accumulation sweeps.
// It generates the per-address ADC config words. Every output is registered from the next-state decode.
module adc_acq_sequencer #(
    parameter int FRAME_CYCLES = 320,
    parameter int SAMPLES      = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    adc_acq_sequencer_if.slave    bus,
    output logic [2:0]            state_dbg
);
    localparam int RUN_TOTAL = FRAME_CYCLES * SAMPLES;
    localparam int RUN_W     = (RUN_TOTAL > 1) ? $clog2(RUN_TOTAL) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_TOTAL - 1);
    localparam logic [11:0]      CLR_LAST = 12'(SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ARM    = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t           state, next_state;
    logic [RUN_W-1:0] run_cnt, run_cnt_d;
    logic [15:0]      pass_lim;
    logic             start_acc, clr_last, run_last;
    logic [15:0]      pass_next;

    logic             adc_start_d, adc_wr_en_d, clr_we_d, busy_d, done_d;
    logic [11:0]      clr_addr_d;
    logic [15:0]      pass_count_d;

    // SDI is LSB-first, so bit0 is the first bit shifted out to the ADC.
    function automatic logic [31:0] cfg_word(input logic [2:0] ch, input logic uni);
        cfg_word = {26'd0, 1'b0, uni, ch[1], ch[2], ch[0], 1'b1};
    endfunction

    assign state_dbg = state;

    // FINISH already reports busy = 0, so a start arriving in that cycle is accepted as well.
    assign start_acc = ((state == S_IDLE) || (state == S_FINISH)) &&
                       bus.cfg_start && !bus.cfg_abort;
    assign clr_last  = (bus.clr_addr == CLR_LAST);
    assign run_last  = (run_cnt == RUN_LAST);
    assign pass_next = (bus.pass_count == 16'hFFFF) ? 16'hFFFF : bus.pass_count + 16'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (bus.cfg_abort && (state != S_IDLE)) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_FINISH: next_state = start_acc ? S_CLEAR : S_IDLE;
                S_CLEAR:          if (clr_last) next_state = S_ARM;
                S_ARM:            next_state = S_RUN;
                S_RUN:            if (run_last) next_state = (pass_next < pass_lim) ? S_ARM : S_FINISH;
                default:          next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        adc_start_d  = (next_state == S_ARM);
        adc_wr_en_d  = (next_state == S_RUN);
        clr_we_d     = (next_state == S_CLEAR);
        busy_d       = adc_start_d || adc_wr_en_d || clr_we_d;
        clr_addr_d   = ((state == S_CLEAR) && (next_state == S_CLEAR)) ? bus.clr_addr + 12'd1 : 12'd0;
        run_cnt_d    = ((state == S_RUN) && (next_state == S_RUN)) ? run_cnt + RUN_W'(1) : '0;
        done_d       = bus.done;
        pass_count_d = bus.pass_count;
        if (start_acc) begin
            done_d       = 1'b0;
            pass_count_d = 16'd0;
        end else begin
            if (next_state == S_FINISH) done_d = 1'b1;
            // A pass counts only when the sweep completes without an abort.
            if ((state == S_RUN) && run_last && (next_state != S_IDLE)) pass_count_d = pass_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.adc_start       <= 1'b0;
            bus.adc_wr_en       <= 1'b0;
            bus.clr_we          <= 1'b0;
            bus.clr_addr        <= 12'd0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.pass_count      <= 16'd0;
            bus.adc_config_even <= 32'd0;
            bus.adc_config_odd  <= 32'd0;
            run_cnt             <= '0;
            pass_lim            <= 16'd1;
        end else begin
            bus.adc_start  <= adc_start_d;
            bus.adc_wr_en  <= adc_wr_en_d;
            bus.clr_we     <= clr_we_d;
            bus.clr_addr   <= clr_addr_d;
            bus.busy       <= busy_d;
            bus.done       <= done_d;
            bus.pass_count <= pass_count_d;
            run_cnt        <= run_cnt_d;
            if (start_acc) begin
                bus.adc_config_even <= cfg_word(bus.cfg_ch_even, bus.cfg_uni);
                bus.adc_config_odd  <= cfg_word(bus.cfg_ch_odd, bus.cfg_uni);
                pass_lim            <= (bus.cfg_passes == 16'd0) ? 16'd1 : bus.cfg_passes;
            end
        end
    end
endmodule

// File: doc/adc_acq_sequencer.md
ADC_ACQ_SEQUENCER -- requirements
Module: adc_acq_sequencer

Parameters
REQ-001 SHALL have parameter FRAME_CYCLES, default 320, meaning clk cycles per ADC conversion frame.
REQ-002 SHALL have parameter SAMPLES, default 4096, meaning RAM words per sweep (address width fixed at 12 bits).

Interface
REQ-003 clk  input  1  160 MHz system clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous reset, active-low.
REQ-005 cfg_start  input  1  single-cycle request to begin an acquisition.
REQ-006 cfg_abort  input  1  single-cycle request to stop immediately.
REQ-007 cfg_passes  input  16  number of accumulation sweeps; 0 is treated as 1.
REQ-008 cfg_ch_even / cfg_ch_odd  input  3 each  single-ended channel for even/odd RAM addresses.
REQ-009 cfg_uni  input  1  1 = unipolar, 0 = bipolar.
REQ-010 adc_start  output  1  restart pulse to the capture datapath.
REQ-011 adc_config_even / adc_config_odd  output  32 each  per-address ADC config words.
REQ-012 adc_wr_en  output  1  gate ANDed at top level with the capture RAM write enable.
REQ-013 clr_we / clr_addr  output  1 / 12  zero-fill RAM write port (write data is constant 0).
REQ-014 busy / done / pass_count  output  1 / 1 / 16  status to host.

Function
REQ-015 Config word: bit0 = S/D (1), bit1 = O/S (ch[0]), bit2 = S1 (ch[2]), bit3 = S0 (ch[1]), bit4 = UNI, bit5 = SLP (0), bits[31:6] = 0.
REQ-016 Bit order is LSB-first on the SDI wire.
REQ-017 Config words, passes and UNI SHALL be latched on an accepted cfg_start and held constant until the next accepted start.
REQ-018 FSM states: IDLE, CLEAR, ARM, RUN, FINISH.
REQ-019 IDLE: cfg_start -> CLEAR.
- pass_count <= 0, done <= 0, busy <= 1 on the next edge.
REQ-020 CLEAR: clr_we = 1 for exactly SAMPLES consecutive cycles, clr_addr 0..SAMPLES-1 ascending, then -> ARM.
REQ-021 ARM: adc_start = 1 for exactly one cycle, then -> RUN.
REQ-022 RUN: adc_wr_en = 1, counting FRAME_CYCLES*SAMPLES cycles starting the cycle after the adc_start pulse.
- Counter width is 21 bits minimum for the defaults.
REQ-023 RUN terminal count: pass_count increments.
- If the new pass_count < effective passes -> ARM.
- Otherwise -> FINISH.
REQ-024 FINISH: one cycle.
- done <= 1, busy <= 0, adc_wr_en <= 0, then -> IDLE.
- done stays high until the next accepted cfg_start or reset.
REQ-025 adc_wr_en SHALL be 0 in every state other than RUN, including during ARM.
REQ-026 cfg_start while busy = 1 SHALL be ignored.
REQ-027 cfg_abort in any non-IDLE state -> IDLE on the next edge.
- adc_wr_en, clr_we, adc_start, busy <= 0.
- done unchanged (stays 0).
- pass_count holds its value.
REQ-028 cfg_abort and cfg_start in the same cycle: abort wins, start discarded.
REQ-029 pass_count SHALL saturate at 16'hFFFF and never wrap.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-031 reset_n = 0 at a clock edge SHALL force the following, regardless of state, including mid-CLEAR or mid-RUN:
- state IDLE
- adc_start, adc_wr_en, clr_we, busy, done = 0
- clr_addr, pass_count = 0
- both config words = 0
REQ-032 First cfg_start accepted is the one sampled on the first edge with reset_n = 1.

Verification (bench uses FRAME_CYCLES = 8, SAMPLES = 16)
REQ-033 Start, passes = 2, ch_even = 2, ch_odd = 1, uni = 1:
- 16 clr_we cycles on addr 0..15
- adc_start pulse, 128 cycles adc_wr_en, adc_start pulse, 128 cycles adc_wr_en
- done = 1, pass_count = 2
- config_even = 0x19, config_odd = 0x13
REQ-034 passes = 0 -> exactly one adc_start pulse and one RUN; pass_count = 1.
REQ-035 cfg_abort at cycle 50 of first RUN:
- adc_wr_en low next cycle, busy = 0, done = 0, pass_count = 0
- no further adc_start
REQ-036 cfg_start pulsed during RUN, and cfg_start+cfg_abort together in CLEAR:
- start ignored and latched config unchanged
- abort wins
REQ-037 reset_n low for 1 cycle mid-CLEAR (clr_addr = 7) -> all outputs zero next cycle.
- A new start then restarts clear from addr 0.
REQ-038 Change cfg_ch_even during RUN -> adc_config_even unchanged until the next accepted start.
